// File: rtl/warp_issue_sched.sv
// warp_issue_sched: per-SM warp lifecycle tracking, replay-first round-robin issue arbitration and
// writeback-to-wup pulse generation. Optional macro AGING_PROMOTE_EN promotes long-waiting warps.

module warp_issue_slot #(
  parameter int AGE_LIMIT = 15,
  parameter int AGE_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic grant,
  input  logic wb_hit,
  input  logic wb_contention,
  input  logic wb_exit,
  output logic busy,
  output logic is_ready,
  output logic is_replay,
  output logic aged,
  output logic wup,
  output logic err
);
  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, INFLIGHT = 2'd2, REPLAY = 2'd3} wstate_e;
  wstate_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (start) state_d = READY;
      READY, REPLAY: if (grant) state_d = INFLIGHT;
      INFLIGHT:      if (wb_hit) state_d = wb_contention ? REPLAY : (wb_exit ? IDLE : READY);
      default:       state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  assign busy      = (state_q != IDLE);
  assign is_ready  = (state_q == READY);
  assign is_replay = (state_q == REPLAY);
  assign wup       = wb_hit & (state_q == INFLIGHT);
  // A start to a busy warp is dropped; a writeback to a non-INFLIGHT warp produces no wup.
  assign err       = (start & busy) | (wb_hit & (state_q != INFLIGHT));

`ifdef AGING_PROMOTE_EN
  logic [AGE_WIDTH-1:0] age_q, age_d;

  always_comb begin
    age_d = '0;
    if ((is_ready | is_replay) && !grant) age_d = (&age_q) ? age_q : age_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) age_q <= '0;
    else     age_q <= age_d;

  assign aged = (is_ready | is_replay) && (int'(age_q) >= AGE_LIMIT);
`else
  assign aged = 1'b0;
`endif
endmodule

module warp_issue_sched #(
  parameter int NUM_WARPS = 8,
  parameter int WID_WIDTH = $clog2(NUM_WARPS),
  parameter int AGE_LIMIT = 15,
  parameter int AGE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] warp_start,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [WID_WIDTH-1:0] issue_wid,
  input  logic                 wb_valid,
  input  logic [WID_WIDTH-1:0] wb_wid,
  input  logic                 wb_contention,
  input  logic                 wb_exit,
  output logic [NUM_WARPS-1:0] wup_o,
  output logic                 contention_o,
  output logic [NUM_WARPS-1:0] warp_busy,
  output logic                 all_idle,
  output logic                 err
);
  typedef struct packed {
    logic                 found;
    logic [WID_WIDTH-1:0] wid;
  } pick_t;

  // First requester at or above ptr, wrapping; wid stays 0 when nothing is found.
  function automatic pick_t rr_pick(input logic [NUM_WARPS-1:0] req, input logic [WID_WIDTH-1:0] ptr);
    pick_t          p;
    logic [WID_WIDTH:0] sum;
    p = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      sum = {1'b0, ptr} + (WID_WIDTH+1)'(k);
      if (sum >= (WID_WIDTH+1)'(NUM_WARPS)) sum = sum - (WID_WIDTH+1)'(NUM_WARPS);
      if (!p.found && req[sum[WID_WIDTH-1:0]]) begin
        p.found = 1'b1;
        p.wid   = sum[WID_WIDTH-1:0];
      end
    end
    return p;
  endfunction

  logic [NUM_WARPS-1:0] busy, rdy, rep, aged, wup_d, err_v, grant, wb_hit;
  logic [WID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_WARPS-1:0] wup_q;
  logic                 contention_q, contention_d, err_q, err_d;
  pick_t                p_aged, p_rep, p_rdy, win;

  for (genvar i = 0; i < NUM_WARPS; i++) begin : g_warp
    warp_issue_slot #(.AGE_LIMIT(AGE_LIMIT), .AGE_WIDTH(AGE_WIDTH)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .start        (warp_start[i]),
      .grant        (grant[i]),
      .wb_hit       (wb_hit[i]),
      .wb_contention(wb_contention),
      .wb_exit      (wb_exit),
      .busy         (busy[i]),
      .is_ready     (rdy[i]),
      .is_replay    (rep[i]),
      .aged         (aged[i]),
      .wup          (wup_d[i]),
      .err          (err_v[i])
    );
  end

  always_comb begin
    p_aged = rr_pick(aged, ptr_q);
    p_rep  = rr_pick(rep, ptr_q);
    p_rdy  = rr_pick(rdy, ptr_q);
    win    = p_aged.found ? p_aged : (p_rep.found ? p_rep : p_rdy);
  end

  assign issue_valid = win.found;
  assign issue_wid   = win.wid;
  assign grant       = (issue_valid && issue_ready) ? (NUM_WARPS'(1) << issue_wid) : '0;
  assign wb_hit      = wb_valid ? (NUM_WARPS'(1) << wb_wid) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (issue_valid && issue_ready)
      ptr_d = (issue_wid == WID_WIDTH'(NUM_WARPS-1)) ? '0 : issue_wid + 1'b1;
    contention_d = wb_valid & wb_contention;
    err_d        = err_q | (|err_v);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q        <= '0;
      wup_q        <= '0;
      contention_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      wup_q        <= wup_d;
      contention_q <= contention_d;
      err_q        <= err_d;
    end

  assign wup_o        = wup_q;
  assign contention_o = contention_q;
  assign err          = err_q;
  assign warp_busy    = busy;
  assign all_idle     = ~|busy;
endmodule

// File: tb/tb_warp_issue_sched.sv
// Scoreboard bench for warp_issue_sched: directed scenarios plus random traffic against a
// queue/array reference model of the warp lifecycle and replay-first round-robin arbitration.

module tb_warp_issue_sched;
  localparam int N = 8;
  localparam int W = 3;
  localparam int S_IDLE = 0, S_RDY = 1, S_INF = 2, S_REP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] warp_start;
  logic         issue_ready, issue_valid;
  logic [W-1:0] issue_wid;
  logic         wb_valid;
  logic [W-1:0] wb_wid;
  logic         wb_contention, wb_exit;
  logic [N-1:0] wup_o;
  logic         contention_o;
  logic [N-1:0] warp_busy;
  logic         all_idle, err;

  warp_issue_sched #(.NUM_WARPS(N)) dut (
    .clk(clk), .rst(rst), .warp_start(warp_start), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_wid(issue_wid), .wb_valid(wb_valid), .wb_wid(wb_wid),
    .wb_contention(wb_contention), .wb_exit(wb_exit), .wup_o(wup_o), .contention_o(contention_o),
    .warp_busy(warp_busy), .all_idle(all_idle), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           edge_n;
    logic [N-1:0] wup;
    logic         cont;
  } exp_t;

  int   checks = 0, failures = 0;
  int   st[N];
  int   ptr;
  bit   m_err;
  int   mon_edge = 0;
  exp_t sb[$];
  int   grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner per the priority rules: REPLAY class first, then READY, each searched upward from ptr.
  function automatic int pick();
    int cls[2] = '{S_REP, S_RDY};
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < N; k++)
        if (st[(ptr + k) % N] == cls[c]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic check_outputs();
    int           p;
    logic [N-1:0] b;
    p = pick();
    for (int i = 0; i < N; i++) b[i] = (st[i] != S_IDLE);
    chk("issue_valid", issue_valid, (p >= 0));
    chk("issue_wid", issue_wid, (p >= 0) ? p : 0);
    chk("warp_busy", warp_busy, b);
    chk("all_idle", all_idle, (b == '0));
    chk("err", err, m_err);
  endtask

  // One cycle: check current outputs, drive inputs, advance the model to the post-edge state.
  task automatic step(input logic [N-1:0] s, input bit rdy, input bit wv, input int ww,
                      input bit c, input bit ex);
    int   p;
    int   nst[N];
    exp_t e;
    @(negedge clk);
    check_outputs();
    warp_start = s; issue_ready = rdy; wb_valid = wv; wb_wid = W'(ww);
    wb_contention = c; wb_exit = ex;
    p = pick();
    nst = st;
    for (int i = 0; i < N; i++)
      if (s[i]) begin
        if (st[i] == S_IDLE) nst[i] = S_RDY;
        else m_err = 1'b1;
      end
    if (p >= 0 && rdy) begin
      nst[p] = S_INF;
      ptr = (p + 1) % N;
      grant_log.push_back(p);
    end
    if (wv) begin
      if (st[ww] == S_INF) begin
        nst[ww] = c ? S_REP : (ex ? S_IDLE : S_RDY);
        e.edge_n = mon_edge + 1;
        e.wup    = N'(1) << ww;
        e.cont   = c;
        sb.push_back(e);
      end else m_err = 1'b1;
    end
    st = nst;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    warp_start = '0; issue_ready = 0; wb_valid = 0; wb_wid = '0; wb_contention = 0; wb_exit = 0;
    #1;
    chk("rst_all_idle", all_idle, 1);
    chk("rst_warp_busy", warp_busy, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_wup", wup_o, 0);
    sb.delete();
    grant_log.delete();
    for (int i = 0; i < N; i++) st[i] = S_IDLE;
    ptr = 0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_phase(input int cycles);
    logic [N-1:0] s;
    int           inf[$];
    bit           wv;
    int           ww;
    for (int n = 0; n < cycles; n++) begin
      s = '0; wv = 0; ww = 0; inf.delete();
      for (int i = 0; i < N; i++) begin
        if (st[i] == S_IDLE && $urandom_range(0, 7) == 0) s[i] = 1'b1;
        if (st[i] == S_INF) inf.push_back(i);
      end
      if ($urandom_range(0, 299) == 0) s[$urandom_range(0, N-1)] = 1'b1;
      if (inf.size() > 0 && $urandom_range(0, 9) < 6) begin
        wv = 1; ww = inf[$urandom_range(0, inf.size() - 1)];
      end
      step(s, ($urandom_range(0, 3) != 0), wv, ww, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0));
    end
  endtask

  // Monitor: after every edge, a wup/contention pulse must match the scoreboard head or be absent.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mon_edge++;
      if (sb.size() > 0 && sb[0].edge_n == mon_edge) begin
        e = sb.pop_front();
        chk("wup_o", wup_o, e.wup);
        chk("contention_o", contention_o, e.cont);
      end else begin
        chk("wup_o_quiet", wup_o, 0);
        chk("contention_o_quiet", contention_o, 0);
      end
    end
  end

  initial begin
    int           rr_exp[6] = '{0, 3, 7, 0, 3, 7};
    logic [W-1:0] held;
    rst = 1'b1;
    warp_start = '0; issue_ready = 0; wb_valid = 0; wb_wid = '0; wb_contention = 0; wb_exit = 0;
    for (int i = 0; i < N; i++) st[i] = S_IDLE;
    ptr = 0; m_err = 1'b0;
    do_reset();

    // Round-robin with immediate writebacks, pointer wrapping 7 -> 0.
    step(8'b1000_1001, 0, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    step('0, 1, 1, 0, 0, 0);
    step('0, 1, 1, 3, 0, 0);
    step('0, 1, 1, 7, 0, 0);
    step('0, 1, 1, 0, 0, 0);
    step('0, 1, 1, 3, 0, 0);
    chk("rr_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], rr_exp[k]);

    // Mid-run reset with warps 2 and 5 INFLIGHT.
    do_reset();
    step(8'b0010_0100, 0, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    do_reset();

    // Replay priority: pointer at 1, warps 1 and 4 READY, warp 6 returns with contention.
    step(8'b0100_0000, 0, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    step(8'b0000_0001, 0, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    step(8'b0001_0010, 0, 0, 0, 0, 0);
    step('0, 0, 1, 6, 1, 0);
    grant_log.delete();
    step('0, 1, 0, 0, 0, 0);
    chk("replay_wup", wup_o, 8'b0100_0000);
    chk("replay_cont", contention_o, 1);
    chk("replay_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 6);

    // Exit, then contention overriding exit.
    do_reset();
    step(8'b0000_0100, 0, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    step('0, 0, 1, 2, 0, 1);
    step('0, 0, 0, 0, 0, 0);
    chk("exit_busy2", warp_busy[2], 0);
    chk("exit_wup2", wup_o[2], 1);
    step(8'b0000_0100, 0, 0, 0, 0, 0);
    step('0, 1, 0, 0, 0, 0);
    step(8'b0001_0000, 0, 1, 2, 1, 1);
    step('0, 0, 0, 0, 0, 0);
    chk("cont_exit_busy2", warp_busy[2], 1);
    chk("cont_exit_wid", issue_wid, 2);

    // Stall: issue_wid must hold across five unready cycles.
    held = issue_wid;
    for (int k = 0; k < 5; k++) begin
      step('0, 0, 0, 0, 0, 0);
      chk("stall_wid", issue_wid, held);
    end

    // Random traffic.
    do_reset();
    rand_phase(3000);

    // Writeback to an IDLE warp sets a sticky error.
    do_reset();
    step('0, 0, 1, 3, 0, 0);
    step('0, 0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 0, 0);
    chk("err_sticky", err, 1);

    step('0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
